// File: rtl/iter_shift_unit.sv
// Iterative shift engine: one accepted request is shifted one bit per clock,
// then the result is held on a valid/ready output until the consumer takes it.
module iter_shift_unit #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             in_arith,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] shifted;
  logic             dir;
  logic             arith;
  logic             move;
  logic [AMT_W-1:0] count;

  // Single-bit primitive: zero-fill on the left, optional sign-fill on the right.
  assign shifted = dir ? {arith & data[WIDTH-1], data[WIDTH-1:1]}
                       : {data[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data      <= '0;
      dir       <= 1'b0;
      arith     <= 1'b0;
      move      <= 1'b0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data     <= in_data;
            dir      <= in_dir;
            arith    <= in_arith;
            // A zero-amount request still spends one SHIFT cycle without moving
            // the data, so latency is uniformly max(amt, 1) edges.
            move     <= (in_amt != '0);
            count    <= (in_amt == '0) ? AMT_W'(1) : in_amt;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          if (move) data <= shifted;
          count <= count - AMT_W'(1);
          if (count == AMT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= move ? shifted : data;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
